// File: rtl/connect4_pkg.sv
// rtl/connect4_pkg.sv - shared Connect Four types and encodings
// Board geometry defaults are shared with the column datapaths and the win checker.
package connect4_pkg;

  localparam int NUM_COLS_DEF = 7;
  localparam int NUM_ROWS_DEF = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CHECK = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam logic PLAYER_RED   = 1'b0;
  localparam logic PLAYER_BLACK = 1'b1;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_RED   = 2'b01;
  localparam logic [1:0] WIN_BLACK = 2'b10;
  localparam logic [1:0] WIN_DRAW  = 2'b11;

  // Winner code for the player who made the winning move.
  function automatic logic [1:0] winner_of(input logic player);
    return (player == PLAYER_BLACK) ? WIN_BLACK : WIN_RED;
  endfunction

endpackage

// File: rtl/key_event_detect.sv
// rtl/key_event_detect.sv - one-cycle key event from a level keycode
// Ports: frame_clk, Reset (sync, active-high), keycode (0 = no key),
//        key_event (one-cycle pulse), event_code (keycode qualifying the event, else 0).
module key_event_detect (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  output logic       key_event,
  output logic [7:0] event_code
);

  logic [7:0] prev_key_q;

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      prev_key_q <= 8'h00;
    end else begin
      prev_key_q <= keycode;
    end
  end

  // A held key fires only on its first cycle; key release (0) never fires.
  assign key_event  = (keycode != prev_key_q) && (keycode != 8'h00);
  assign event_code = key_event ? keycode : 8'h00;

endmodule

// File: rtl/drop_turn_ctrl.sv
// rtl/drop_turn_ctrl.sv - Connect Four game sequencer
// Ports: frame_clk, Reset (sync, active-high), keycode,
//        drop_ack / drop_valid, drop_col, drop_row, drop_player (column handshake),
//        check_req / check_done, win_found (win checker handshake),
//        board_clear, invalid_move (pulses), cur_player, move_count, game_over, winner.
module drop_turn_ctrl
  import connect4_pkg::*;
#(
  parameter int         NUM_COLS    = NUM_COLS_DEF,
  parameter int         NUM_ROWS    = NUM_ROWS_DEF,
  parameter logic [7:0] KEY_COL0    = 8'h1E,
  parameter logic [7:0] KEY_RESTART = 8'h29
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       drop_ack,
  input  logic       check_done,
  input  logic       win_found,
  output logic       drop_valid,
  output logic [2:0] drop_col,
  output logic [2:0] drop_row,
  output logic       drop_player,
  output logic       check_req,
  output logic       board_clear,
  output logic       invalid_move,
  output logic       cur_player,
  output logic [5:0] move_count,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam logic [2:0] ROWS3       = 3'(NUM_ROWS);
  localparam logic [7:0] COLS8       = 8'(NUM_COLS);
  localparam logic [5:0] TOTAL_CELLS = 6'(NUM_COLS * NUM_ROWS);

  state_t state_q, state_d;

  logic [NUM_COLS-1:0][2:0] heights_q;
  logic [2:0]               drop_col_q, drop_row_q;
  logic                     drop_player_q;
  logic                     cur_player_q;
  logic [5:0]               move_count_q;
  logic [1:0]               winner_q, winner_d;
  logic                     board_clear_q, invalid_q, check_first_q;

  logic       key_event;
  logic [7:0] event_code;
  logic [7:0] key_diff;
  logic [2:0] key_col;
  logic       is_col_key;
  logic       is_restart;
  logic [2:0] col_height;

  logic do_load, do_ack, do_clear, do_bad, do_toggle;

  key_event_detect u_key (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .keycode    (keycode),
    .key_event  (key_event),
    .event_code (event_code)
  );

  // Unsigned subtraction wraps keys below KEY_COL0 to large values, so one compare suffices.
  assign key_diff   = event_code - KEY_COL0;
  assign key_col    = key_diff[2:0];
  assign is_col_key = key_event && (key_diff < COLS8);
  assign is_restart = key_event && (event_code == KEY_RESTART);
  assign col_height = heights_q[key_col];

  always_comb begin
    state_d   = state_q;
    winner_d  = winner_q;
    do_load   = 1'b0;
    do_ack    = 1'b0;
    do_clear  = 1'b0;
    do_bad    = 1'b0;
    do_toggle = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_restart) begin
          do_clear = 1'b1;
        end else if (is_col_key) begin
          if (col_height < ROWS3) begin
            do_load = 1'b1;
            state_d = ISSUE;
          end else begin
            do_bad = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (drop_ack) begin
          do_ack  = 1'b1;
          state_d = CHECK;
        end
      end
      CHECK: begin
        // move_count already includes this move, so a full board reads TOTAL_CELLS here.
        if (check_done) begin
          if (win_found) begin
            winner_d = winner_of(drop_player_q);
            state_d  = OVER;
          end else if (move_count_q == TOTAL_CELLS) begin
            winner_d = WIN_DRAW;
            state_d  = OVER;
          end else begin
            do_toggle = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      OVER: begin
        if (is_restart) begin
          do_clear = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (do_clear) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q       <= IDLE;
      heights_q     <= '0;
      drop_col_q    <= 3'd0;
      drop_row_q    <= 3'd0;
      drop_player_q <= PLAYER_RED;
      cur_player_q  <= PLAYER_RED;
      move_count_q  <= 6'd0;
      winner_q      <= WIN_NONE;
      board_clear_q <= 1'b0;
      invalid_q     <= 1'b0;
      check_first_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      board_clear_q <= do_clear;
      invalid_q     <= do_bad;
      check_first_q <= do_ack;
      if (do_clear) begin
        heights_q     <= '0;
        drop_col_q    <= 3'd0;
        drop_row_q    <= 3'd0;
        drop_player_q <= PLAYER_RED;
        cur_player_q  <= PLAYER_RED;
        move_count_q  <= 6'd0;
        winner_q      <= WIN_NONE;
      end else begin
        winner_q <= winner_d;
        if (do_load) begin
          drop_col_q    <= key_col;
          drop_row_q    <= col_height;
          drop_player_q <= cur_player_q;
        end
        if (do_ack) begin
          if (heights_q[drop_col_q] < ROWS3) begin
            heights_q[drop_col_q] <= heights_q[drop_col_q] + 3'd1;
          end
          if (move_count_q < TOTAL_CELLS) begin
            move_count_q <= move_count_q + 6'd1;
          end
        end
        if (do_toggle) begin
          cur_player_q <= ~cur_player_q;
        end
      end
    end
  end

  assign drop_valid   = (state_q == ISSUE);
  assign drop_col     = drop_col_q;
  assign drop_row     = drop_row_q;
  assign drop_player  = drop_player_q;
  assign check_req    = (state_q == CHECK) && check_first_q;
  assign board_clear  = board_clear_q;
  assign invalid_move = invalid_q;
  assign cur_player   = cur_player_q;
  assign move_count   = move_count_q;
  assign game_over    = (state_q == OVER);
  assign winner       = winner_q;

endmodule

// File: tb/tb_drop_turn_ctrl.sv
// tb/tb_drop_turn_ctrl.sv - self-checking bench for drop_turn_ctrl
module tb_drop_turn_ctrl;

  logic       frame_clk;
  logic       Reset;
  logic [7:0] keycode;
  logic       drop_ack, check_done, win_found;
  logic       drop_valid;
  logic [2:0] drop_col, drop_row;
  logic       drop_player, check_req, board_clear, invalid_move, cur_player;
  logic [5:0] move_count;
  logic       game_over;
  logic [1:0] winner;

  int n_cmp = 0;
  int n_bad = 0;

  drop_turn_ctrl dut (
    .frame_clk    (frame_clk),
    .Reset        (Reset),
    .keycode      (keycode),
    .drop_ack     (drop_ack),
    .check_done   (check_done),
    .win_found    (win_found),
    .drop_valid   (drop_valid),
    .drop_col     (drop_col),
    .drop_row     (drop_row),
    .drop_player  (drop_player),
    .check_req    (check_req),
    .board_clear  (board_clear),
    .invalid_move (invalid_move),
    .cur_player   (cur_player),
    .move_count   (move_count),
    .game_over    (game_over),
    .winner       (winner)
  );

  initial begin
    frame_clk = 1'b0;
    forever #5 frame_clk = ~frame_clk;
  end

  // {dv, col, row, player, check_req, board_clear, invalid, cur_player, move_count, game_over, winner}
  logic [20:0] obs;
  assign obs = {drop_valid, drop_col, drop_row, drop_player, check_req, board_clear,
                invalid_move, cur_player, move_count, game_over, winner};

  typedef struct {
    string       name;
    logic        rst;
    logic [7:0]  key;
    logic        ack;
    logic        done;
    logic        win;
    logic [20:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [20:0] pk(input logic dv, input logic [2:0] col, input logic [2:0] row,
                                     input logic pl, input logic cr, input logic bc, input logic inv,
                                     input logic cur, input logic [5:0] mc, input logic go,
                                     input logic [1:0] w);
    return {dv, col, row, pl, cr, bc, inv, cur, mc, go, w};
  endfunction

  task automatic add(input string nm, input logic rst, input logic [7:0] key, input logic ack,
                     input logic done, input logic win, input logic [20:0] exp);
    vec_t v;
    v.name = nm; v.rst = rst; v.key = key; v.ack = ack; v.done = done; v.win = win; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic cyc(input logic rst, input logic [7:0] key, input logic ack,
                     input logic done, input logic win);
    Reset = rst; keycode = key; drop_ack = ack; check_done = done; win_found = win;
    @(posedge frame_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [20:0] got, input logic [20:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // One full move: key, ack, check_done; checks the drop fields and the check request.
  task automatic do_move(input string nm, input int col, input int row, input logic pl, input logic win);
    logic [7:0] k;
    k = 8'h1E + 8'(col);
    cyc(1'b0, k, 1'b0, 1'b0, 1'b0);
    chk({nm, " drop"}, {13'd0, drop_valid, drop_col, drop_row, drop_player},
        {13'd0, 1'b1, 3'(col), 3'(row), pl});
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk({nm, " creq"}, {19'd0, drop_valid, check_req}, {19'd0, 1'b0, 1'b1});
    cyc(1'b0, 8'h00, 1'b0, 1'b1, win);
  endtask

  initial begin
    Reset = 1'b1; keycode = 8'h00; drop_ack = 1'b0; check_done = 1'b0; win_found = 1'b0;

    add("reset",          1, 8'h00, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add("key1e",          0, 8'h1E, 0, 0, 0, pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add("held1",          0, 8'h1E, 0, 0, 0, pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add("held2",          0, 8'h1E, 0, 0, 0, pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add("held3",          0, 8'h1E, 0, 0, 0, pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add("held4",          0, 8'h1E, 0, 0, 0, pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add("ack1",           0, 8'h00, 1, 0, 0, pk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0));
    add("done1",          0, 8'h00, 0, 1, 0, pk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    add("key1f",          0, 8'h1F, 0, 0, 0, pk(1, 1, 0, 1, 0, 0, 0, 1, 1, 0, 0));
    add("restart_issue",  0, 8'h29, 0, 0, 0, pk(1, 1, 0, 1, 0, 0, 0, 1, 1, 0, 0));
    add("ack2",           0, 8'h29, 1, 0, 0, pk(0, 1, 0, 1, 1, 0, 0, 1, 2, 0, 0));
    add("done2",          0, 8'h29, 0, 1, 0, pk(0, 1, 0, 1, 0, 0, 0, 0, 2, 0, 0));
    add("stray_ack",      0, 8'h00, 1, 0, 0, pk(0, 1, 0, 1, 0, 0, 0, 0, 2, 0, 0));
    add("restart_idle",   0, 8'h29, 0, 0, 0, pk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    add("after_clear",    0, 8'h00, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add("key1e_b",        0, 8'h1E, 0, 0, 0, pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add("ack3_otherkey",  0, 8'h05, 1, 0, 0, pk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0));
    add("done3",          0, 8'h05, 0, 1, 0, pk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    add("nonkey_idle",    0, 8'h04, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    add("col7_ignored",   0, 8'h25, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    add("key1e_row1",     0, 8'h1E, 0, 0, 0, pk(1, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0));
    add("ack4",           0, 8'h00, 1, 0, 0, pk(0, 0, 1, 1, 1, 0, 0, 1, 2, 0, 0));
    add("check_wait",     0, 8'h00, 0, 0, 0, pk(0, 0, 1, 1, 0, 0, 0, 1, 2, 0, 0));
    add("reset_midcheck", 1, 8'h00, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add("late_done",      0, 8'h00, 0, 1, 0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add("key1e_post_rst", 0, 8'h1E, 0, 0, 0, pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      cyc(vecs[i].rst, vecs[i].key, vecs[i].ack, vecs[i].done, vecs[i].win);
      chk(vecs[i].name, obs, vecs[i].exp);
    end

    // Six drops into column 3, then the column is full.
    cyc(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int r = 0; r < 6; r++) begin
      do_move("col3", 3, r, 1'(r % 2), 1'b0);
    end
    cyc(1'b0, 8'h21, 1'b0, 1'b0, 1'b0);
    chk("full_col_pulse", obs, pk(0, 3, 5, 1, 0, 0, 1, 0, 6, 0, 0));
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("full_col_single", obs, pk(0, 3, 5, 1, 0, 0, 0, 0, 6, 0, 0));

    // Black wins on the second move; column keys then ignored; restart in OVER.
    cyc(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    do_move("red0", 0, 0, 1'b0, 1'b0);
    do_move("black1", 1, 0, 1'b1, 1'b1);
    chk("black_win", obs, pk(0, 1, 0, 1, 0, 0, 0, 1, 2, 1, 2'b10));
    cyc(1'b0, 8'h1F, 1'b0, 1'b0, 1'b0);
    chk("over_key_ignored", obs, pk(0, 1, 0, 1, 0, 0, 0, 1, 2, 1, 2'b10));
    cyc(1'b0, 8'h29, 1'b0, 1'b0, 1'b0);
    chk("restart_over", obs, pk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("clear_single", obs, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(1'b0, 8'h1E, 1'b0, 1'b0, 1'b0);
    chk("fresh_drop", obs, pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Fill all 42 cells without a win -> draw.
    cyc(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 7; c++) begin
      for (int r = 0; r < 6; r++) begin
        do_move("fill", c, r, 1'((c * 6 + r) % 2), 1'b0);
        if (c == 6 && r == 4) begin
          chk("fill41_not_over", obs, pk(0, 6, 4, 0, 0, 0, 0, 1, 41, 0, 0));
        end
      end
    end
    chk("draw", obs, pk(0, 6, 5, 1, 0, 0, 0, 1, 42, 1, 2'b11));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
